// File: rtl/fusion_out_packer.sv
// Packs two {avg, fused} pixels per 32-bit AXI-Stream word, flags the last word of
// each frame, and decouples input ready from output ready through a 2-entry FIFO.
module fusion_out_packer #(
  parameter int IM_LEN            = 520,
  parameter int IM_WID            = 520,
  parameter int DATA_WIDTH        = 8,
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int FRAME_CNT_WIDTH   = 16
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic                         s_axis_tvalid,
  input  logic [INPUT_DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                         s_axis_tready,
  output logic                         m_axis_tvalid,
  output logic [OUTPUT_DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]   frame_count
);

  localparam int NPIX   = IM_LEN * IM_WID;
  localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LANE_W = 2 * DATA_WIDTH;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  typedef enum logic {S_EMPTY, S_HALF} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [PIX_W-1:0]             r_pix_cnt;
  logic [LANE_W-1:0]            r_lane0;
  logic [OUTPUT_DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]                   r_fifo_last;
  logic                         r_wr_ptr;
  logic                         r_rd_ptr;
  logic [1:0]                   r_count;
  logic                         r_frame_done;
  logic [FRAME_CNT_WIDTH-1:0]   r_frame_count;

  logic                         w_acc;
  logic                         w_pop;
  logic                         w_last_pix;
  logic                         w_push;
  logic                         w_push_last;
  logic                         w_lane_load;
  logic                         w_head_last;
  logic [LANE_W-1:0]            w_in_pix;
  logic [OUTPUT_DATA_WIDTH-1:0] w_push_data;
  logic                         w_unused_in;

  assign w_in_pix    = s_axis_tdata[LANE_W-1:0];
  assign w_unused_in = ^s_axis_tdata[INPUT_DATA_WIDTH-1:LANE_W];

  // Ready looks only at registered occupancy, so a same-cycle pop never raises it.
  assign s_axis_tready = ~axi_reset & (r_count != 2'd2);
  assign w_acc         = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = (r_count != 2'd0);
  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = r_fifo_data[r_rd_ptr];
  assign w_head_last   = r_fifo_last[r_rd_ptr];
  assign m_axis_tlast  = w_head_last;
  assign w_last_pix    = (r_pix_cnt == LAST_PIX);
  assign frame_done    = r_frame_done;
  assign frame_count   = r_frame_count;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_pix_cnt <= '0;
    end else if (w_acc) begin
      r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + PIX_W'(1);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state <= S_EMPTY;
      r_lane0 <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_lane_load) begin
        r_lane0 <= w_in_pix;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_push_data  = '0;
    w_lane_load  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_lane_load = 1'b1;
          // An odd-sized frame ends with a lone pixel padded by a zero upper lane.
          if (w_last_pix) begin
            w_push                   = 1'b1;
            w_push_last              = 1'b1;
            w_push_data[LANE_W-1:0]  = w_in_pix;
          end else begin
            w_state_next = S_HALF;
          end
        end
      end
      S_HALF: begin
        if (w_acc) begin
          w_push                     = 1'b1;
          w_push_last                = w_last_pix;
          w_push_data[2*LANE_W-1:0]  = {w_in_pix, r_lane0};
          w_state_next               = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // A push can only happen when count != 2, so push+pop never overflows.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_pop & w_head_last;
      if (w_pop & w_head_last) begin
        r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fusion_out_packer.sv
// Bench for fusion_out_packer: three instances (4x3, 3x3, 4x3 with 2-bit frame count),
// a pairing/queue reference model checked every cycle, and directed literal checks.
module tb_fusion_out_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  s_valid;
  logic [2:0]  m_ready;
  logic [31:0] s_data [3];
  logic [2:0]  s_ready;
  logic [2:0]  m_valid;
  logic [2:0]  m_last;
  logic [2:0]  fd;
  logic [31:0] md0, md1, md2;
  logic [15:0] fc0, fc1;
  logic [1:0]  fc2;

  fusion_out_packer #(.IM_LEN(4), .IM_WID(3), .DATA_WIDTH(8), .INPUT_DATA_WIDTH(32),
                      .OUTPUT_DATA_WIDTH(32), .FRAME_CNT_WIDTH(16)) dut0 (
    .axi_clk(clk), .axi_reset(rst[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tdata(s_data[0]),
    .s_axis_tready(s_ready[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tdata(md0),
    .m_axis_tready(m_ready[0]), .m_axis_tlast(m_last[0]), .frame_done(fd[0]), .frame_count(fc0));

  fusion_out_packer #(.IM_LEN(3), .IM_WID(3), .DATA_WIDTH(8), .INPUT_DATA_WIDTH(32),
                      .OUTPUT_DATA_WIDTH(32), .FRAME_CNT_WIDTH(16)) dut1 (
    .axi_clk(clk), .axi_reset(rst[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tdata(s_data[1]),
    .s_axis_tready(s_ready[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tdata(md1),
    .m_axis_tready(m_ready[1]), .m_axis_tlast(m_last[1]), .frame_done(fd[1]), .frame_count(fc1));

  fusion_out_packer #(.IM_LEN(4), .IM_WID(3), .DATA_WIDTH(8), .INPUT_DATA_WIDTH(32),
                      .OUTPUT_DATA_WIDTH(32), .FRAME_CNT_WIDTH(2)) dut2 (
    .axi_clk(clk), .axi_reset(rst[2]), .s_axis_tvalid(s_valid[2]), .s_axis_tdata(s_data[2]),
    .s_axis_tready(s_ready[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tdata(md2),
    .m_axis_tready(m_ready[2]), .m_axis_tlast(m_last[2]), .frame_done(fd[2]), .frame_count(fc2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, per instance.
  int          m_idx    [3];
  bit          m_half   [3];
  logic [15:0] m_lane   [3];
  logic [32:0] exp_q    [3][64];
  int          wr       [3];
  int          rd       [3];
  bit          fd_exp   [3];
  int          fc_exp   [3];
  bit          rst_prev [3];
  logic [32:0] pop_log  [3][256];
  int          pop_n    [3];
  int          fd_cnt   [3];
  int          sr_low   [3];

  function automatic logic [31:0] get_md(input int i);
    case (i)
      0:       return md0;
      1:       return md1;
      default: return md2;
    endcase
  endfunction

  function automatic logic [15:0] get_fc(input int i);
    case (i)
      0:       return fc0;
      1:       return fc1;
      default: return {14'b0, fc2};
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_step(input int i);
    logic [31:0] md;
    logic [15:0] fcv;
    logic [15:0] mask;
    logic [32:0] head;
    logic [15:0] px;
    int          pend;
    int          npix;
    bit          pop;
    bit          acc;
    md   = get_md(i);
    fcv  = get_fc(i);
    mask = (i == 2) ? 16'h0003 : 16'hFFFF;
    npix = (i == 1) ? 9 : 12;
    if (rst[i]) begin
      chk(s_ready[i] == 1'b0, "reset_tready", 64'(s_ready[i]), 0);
      if (rst_prev[i]) begin
        chk(m_valid[i] == 1'b0, "reset_tvalid", 64'(m_valid[i]), 0);
        chk(md == 32'h0, "reset_tdata", 64'(md), 0);
        chk(m_last[i] == 1'b0, "reset_tlast", 64'(m_last[i]), 0);
        chk(fd[i] == 1'b0, "reset_frame_done", 64'(fd[i]), 0);
        chk(fcv == 16'h0, "reset_frame_count", 64'(fcv), 0);
      end
      m_idx[i] = 0; m_half[i] = 1'b0; m_lane[i] = '0;
      wr[i] = 0; rd[i] = 0; fd_exp[i] = 1'b0; fc_exp[i] = 0;
      rst_prev[i] = 1'b1;
      return;
    end
    rst_prev[i] = 1'b0;
    if (!s_ready[i]) sr_low[i]++;
    pend = wr[i] - rd[i];
    head = exp_q[i][rd[i] % 64];
    chk(s_ready[i] == (pend != 2), "tready", 64'(s_ready[i]), 64'(pend != 2));
    chk(m_valid[i] == (pend != 0), "tvalid", 64'(m_valid[i]), 64'(pend != 0));
    if (pend != 0 && m_valid[i]) chk({md, m_last[i]} == head, "head_word", 64'({md, m_last[i]}), 64'(head));
    chk(fd[i] == fd_exp[i], "frame_done", 64'(fd[i]), 64'(fd_exp[i]));
    if (fd[i]) fd_cnt[i]++;
    chk(fcv == (16'(fc_exp[i]) & mask), "frame_count", 64'(fcv), 64'(16'(fc_exp[i]) & mask));

    pop = m_valid[i] & m_ready[i];
    acc = s_valid[i] & s_ready[i];
    fd_exp[i] = 1'b0;
    if (pop && pend > 0) begin
      if (head[0]) begin
        fd_exp[i] = 1'b1;
        fc_exp[i]++;
      end
      rd[i]++;
      pop_log[i][pop_n[i] % 256] = {md, m_last[i]};
      pop_n[i]++;
      $display("inst %0d word %08h last %0b", i, md, m_last[i]);
    end
    if (acc) begin
      px = s_data[i][15:0];
      if (!m_half[i]) begin
        if (m_idx[i] == npix - 1) begin
          exp_q[i][wr[i] % 64] = {16'h0000, px, 1'b1};
          wr[i]++;
        end else begin
          m_lane[i] = px;
          m_half[i] = 1'b1;
        end
      end else begin
        exp_q[i][wr[i] % 64] = {px, m_lane[i], m_idx[i] == npix - 1};
        wr[i]++;
        m_half[i] = 1'b0;
      end
      m_idx[i] = (m_idx[i] + 1) % npix;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    tick(3);
    rst[i] = 1'b0;
  endtask

  // Streams pixels k0..k0+n-1 as {avg=0x80+k, fused=k}; upper bits are junk.
  task automatic send_px(input int i, input int n, input int k0, input bit rnd);
    int k;
    int cyc;
    bit acc;
    k   = k0;
    cyc = 0;
    while (k < k0 + n && cyc < 2000) begin
      s_valid[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) m_ready[i] = 1'($urandom_range(0, 1));
      s_data[i] = {16'($urandom), 8'(128 + k), 8'(k)};
      @(negedge clk);
      acc = s_valid[i] & s_ready[i];
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    s_valid[i] = 1'b0;
    chk(k == k0 + n, "send_complete", 64'(k), 64'(k0 + n));
  endtask

  initial begin
    int base;
    int fdb;
    int srb;
    int k;
    int nl;
    bit acc;
    int exp_seq [4];
    exp_seq = '{1, 2, 3, 0};
    rst     = 3'b111;
    s_valid = 3'b000;
    m_ready = 3'b000;
    for (int i = 0; i < 3; i++) s_data[i] = 32'h0;
    fork
      compare_loop();
    join_none
    tick(3);
    rst = 3'b000;
    m_ready = 3'b111;

    // 4x3 frame, back-to-back, downstream always ready.
    base = pop_n[0]; fdb = fd_cnt[0]; srb = sr_low[0];
    send_px(0, 12, 0, 1'b0);
    tick(4);
    chk(pop_n[0] - base == 6, "t1_words", 64'(pop_n[0] - base), 6);
    chk(pop_log[0][base % 256] == {32'h81018000, 1'b0}, "t1_first", 64'(pop_log[0][base % 256]), 64'({32'h81018000, 1'b0}));
    chk(pop_log[0][(base + 5) % 256] == {32'h8B0B8A0A, 1'b1}, "t1_last", 64'(pop_log[0][(base + 5) % 256]), 64'({32'h8B0B8A0A, 1'b1}));
    chk(fd_cnt[0] - fdb == 1, "t1_frame_done", 64'(fd_cnt[0] - fdb), 1);
    chk(fc0 == 16'd1, "t1_frame_count", 64'(fc0), 1);
    chk(sr_low[0] == srb, "t1_tready_held", 64'(sr_low[0] - srb), 0);

    // 3x3 frame: odd pixel count pads the final word.
    base = pop_n[1];
    send_px(1, 9, 0, 1'b0);
    tick(4);
    chk(pop_n[1] - base == 5, "t2_words", 64'(pop_n[1] - base), 5);
    chk(pop_log[1][base % 256] == {32'h81018000, 1'b0}, "t2_first", 64'(pop_log[1][base % 256]), 64'({32'h81018000, 1'b0}));
    chk(pop_log[1][(base + 4) % 256] == {32'h00008808, 1'b1}, "t2_fifth", 64'(pop_log[1][(base + 4) % 256]), 64'({32'h00008808, 1'b1}));
    chk(fc1 == 16'd1, "t2_frame_count", 64'(fc1), 1);

    // Backpressure from reset.
    m_ready[0] = 1'b0;
    do_reset(0);
    base = pop_n[0];
    k = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = {16'hFFFF, 8'(128 + k), 8'(k)};
      @(negedge clk);
      acc = s_valid[0] & s_ready[0];
      if (m_valid[0]) chk(md0 == 32'h81018000, "t3_hold", 64'(md0), 64'h81018000);
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    s_valid[0] = 1'b0;
    chk(k == 4, "t3_accepts", 64'(k), 4);
    chk(s_ready[0] == 1'b0, "t3_tready_low", 64'(s_ready[0]), 0);
    m_ready[0] = 1'b1;
    tick(5);
    chk(pop_n[0] - base == 2, "t3_words", 64'(pop_n[0] - base), 2);
    chk(pop_log[0][base % 256] == {32'h81018000, 1'b0}, "t3_w0", 64'(pop_log[0][base % 256]), 64'({32'h81018000, 1'b0}));
    chk(pop_log[0][(base + 1) % 256] == {32'h83038202, 1'b0}, "t3_w1", 64'(pop_log[0][(base + 1) % 256]), 64'({32'h83038202, 1'b0}));

    // Random valid/ready over 3 frames.
    do_reset(0);
    base = pop_n[0]; fdb = fd_cnt[0];
    send_px(0, 36, 0, 1'b1);
    m_ready[0] = 1'b1;
    tick(6);
    nl = 0;
    for (int j = 0; j < 18; j++) if (pop_log[0][(base + j) % 256][0]) nl++;
    chk(pop_n[0] - base == 18, "t4_words", 64'(pop_n[0] - base), 18);
    chk(nl == 3, "t4_tlast_count", 64'(nl), 3);
    chk(fc0 == 16'd3, "t4_frame_count", 64'(fc0), 3);
    chk(fd_cnt[0] - fdb == 3, "t4_frame_done", 64'(fd_cnt[0] - fdb), 3);

    // Reset after pixel 5, with a word still buffered.
    send_px(0, 6, 0, 1'b0);
    do_reset(0);
    base = pop_n[0];
    send_px(0, 12, 0, 1'b0);
    tick(4);
    chk(pop_n[0] - base == 6, "t5_words", 64'(pop_n[0] - base), 6);
    chk(pop_log[0][base % 256] == {32'h81018000, 1'b0}, "t5_first", 64'(pop_log[0][base % 256]), 64'({32'h81018000, 1'b0}));
    chk(pop_log[0][(base + 5) % 256] == {32'h8B0B8A0A, 1'b1}, "t5_last", 64'(pop_log[0][(base + 5) % 256]), 64'({32'h8B0B8A0A, 1'b1}));
    chk(fc0 == 16'd1, "t5_frame_count", 64'(fc0), 1);

    // 2-bit frame counter wrap.
    for (int f = 0; f < 4; f++) begin
      send_px(2, 12, 0, 1'b0);
      tick(4);
      chk(int'(fc2) == exp_seq[f], "t6_wrap", 64'(fc2), 64'(exp_seq[f]));
    end

    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
